// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, codeword bit positions, TX FSM states
// and the reference encode function reused by the receive-side bench model.
package hamming_pkg;

    localparam int unsigned CW_W   = 7;
    localparam int unsigned DATA_W = 4;

    localparam int unsigned CW_P1 = 0;
    localparam int unsigned CW_P2 = 1;
    localparam int unsigned CW_D0 = 2;
    localparam int unsigned CW_P4 = 3;
    localparam int unsigned CW_D1 = 4;
    localparam int unsigned CW_D2 = 5;
    localparam int unsigned CW_D3 = 6;

    localparam logic [2:0] INJ_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

    function automatic logic [CW_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        cw        = '0;
        cw[CW_D0] = d[0];
        cw[CW_D1] = d[1];
        cw[CW_D2] = d[2];
        cw[CW_D3] = d[3];
        cw[CW_P1] = d[0] ^ d[1] ^ d[3];
        cw[CW_P2] = d[0] ^ d[2] ^ d[3];
        cw[CW_P4] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_encoder.sv
// Combinational Hamming(7,4) encoder: data nibble in, 7-bit codeword out.
module hamming_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CW_W-1:0]   o_cw
);

    always_comb begin
        o_cw = hamming_encode(i_data);
    end

endmodule

// File: rtl/hamming_serial_tx.sv
// Hamming(7,4) serial transmitter: valid/ready nibble intake, one-deep holding
// register, MSB-first shifter with framing strobes and optional bit-flip injection.
module hamming_serial_tx
    import hamming_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [2:0]        inj_pos,
    output logic              serial_out,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int unsigned     GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]       BIT_LAST = 3'(CW_W - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [CW_W-1:0]  r_hold_cw;
    logic             r_hold_full;
    logic [CW_W-1:0]  r_shift;
    logic [2:0]       r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_serial;
    logic             r_bit_valid;
    logic             r_frame_start;

    logic [CW_W-1:0]  w_cw;
    logic [CW_W-1:0]  w_flip;
    logic [CW_W-1:0]  w_cw_tx;
    logic             w_xfer;
    logic             w_last_bit;
    logic             w_gap_done;
    logic             w_load;
    logic             w_serial_nxt;
    logic             w_bit_valid_nxt;
    logic             w_frame_start_nxt;

    hamming_encoder u_encoder (
        .i_data (in_data),
        .o_cw   (w_cw)
    );

    always_comb begin
        w_flip = '0;
        if (inj_en && (inj_pos != INJ_NONE)) begin
            w_flip = CW_W'(1) << inj_pos;
        end
        w_cw_tx = w_cw ^ w_flip;
    end

    assign w_xfer     = in_valid & ~r_hold_full;
    assign w_last_bit = (r_bit_cnt == BIT_LAST);
    assign w_gap_done = (r_gap_cnt == GAP_LAST);

    // A frame is loaded from the holding register at any edge where the line is free.
    always_comb begin
        w_load = 1'b0;
        if (r_hold_full) begin
            unique case (r_state)
                ST_IDLE:  w_load = 1'b1;
                ST_SHIFT: w_load = w_last_bit && (GAP_CYCLES == 0);
                ST_GAP:   w_load = w_gap_done;
                default:  w_load = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_hold_full) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    if (GAP_CYCLES > 0)   w_state_nxt = ST_GAP;
                    else if (r_hold_full) w_state_nxt = ST_SHIFT;
                    else                  w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_gap_done) w_state_nxt = r_hold_full ? ST_SHIFT : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered: these are the values the line shows after the coming edge.
    always_comb begin
        w_serial_nxt      = 1'b0;
        w_bit_valid_nxt   = 1'b0;
        w_frame_start_nxt = 1'b0;
        if (w_load) begin
            w_serial_nxt      = r_hold_cw[CW_W-1];
            w_bit_valid_nxt   = 1'b1;
            w_frame_start_nxt = 1'b1;
        end else if ((r_state == ST_SHIFT) && !w_last_bit) begin
            w_serial_nxt    = r_shift[CW_W-1];
            w_bit_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_hold_cw     <= '0;
            r_hold_full   <= 1'b0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_serial      <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_serial      <= w_serial_nxt;
            r_bit_valid   <= w_bit_valid_nxt;
            r_frame_start <= w_frame_start_nxt;

            if (w_xfer) begin
                r_hold_cw   <= w_cw_tx;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            // The shifter holds the bits still to be sent; cw[6] goes straight to the output.
            if (w_load) begin
                r_shift   <= {r_hold_cw[CW_W-2:0], 1'b0};
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_shift   <= {r_shift[CW_W-2:0], 1'b0};
                r_bit_cnt <= w_last_bit ? 3'd0 : r_bit_cnt + 3'd1;
            end

            if ((r_state == ST_GAP) && !w_gap_done) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            else                                    r_gap_cnt <= '0;
        end
    end

    assign serial_out  = r_serial;
    assign bit_valid   = r_bit_valid;
    assign frame_start = r_frame_start;
    assign in_ready    = ~r_hold_full;
    assign busy        = (r_state != ST_IDLE) | r_hold_full;

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Directed bench for hamming_serial_tx: encode table, full nibble sweep against a
// positional-parity model, back-to-back and gapped framing, and mid-frame reset.
module tb_hamming_serial_tx;

    logic       clk;
    logic       reset;

    logic       in_valid0, in_ready0, inj_en0, serial0, bv0, fs0, busy0;
    logic [3:0] in_data0;
    logic [2:0] inj_pos0;
    logic       in_valid1, in_ready1, inj_en1, serial1, bv1, fs1, busy1;
    logic [3:0] in_data1;
    logic [2:0] inj_pos1;

    int n_checks;
    int n_fail;

    logic [31:0] lg_bv, lg_ser, lg_fs, lg_rdy, lg_busy;

    typedef struct {
        logic [3:0] data;
        logic       inj_en;
        logic [2:0] inj_pos;
        logic [6:0] exp_cw;
    } vec_t;

    vec_t vecs[7];

    hamming_serial_tx #(.GAP_CYCLES(0)) u_dut0 (
        .clk (clk), .reset (reset),
        .in_valid (in_valid0), .in_ready (in_ready0), .in_data (in_data0),
        .inj_en (inj_en0), .inj_pos (inj_pos0),
        .serial_out (serial0), .bit_valid (bv0), .frame_start (fs0), .busy (busy0)
    );

    hamming_serial_tx #(.GAP_CYCLES(3)) u_dut1 (
        .clk (clk), .reset (reset),
        .in_valid (in_valid1), .in_ready (in_ready1), .in_data (in_data1),
        .inj_en (inj_en1), .inj_pos (inj_pos1),
        .serial_out (serial1), .bit_valid (bv1), .frame_start (fs1), .busy (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parity bit at position 2^k covers every 1-based position with bit k set.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [7:1] pos;
        logic [6:0] cw;
        logic       p;
        pos    = '0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int j = 1; j <= 7; j++) begin
                if (((j >> k) & 1) != 0) p = p ^ pos[j];
            end
            pos[1 << k] = p;
        end
        for (int i = 0; i < 7; i++) cw[i] = pos[i + 1];
        return cw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends one nibble to the gapless DUT and captures the resulting frame.
    task automatic run_frame(input logic [3:0] d, input logic ie, input logic [2:0] ip,
                             output logic [6:0] cw, output int lat, output int nbits,
                             output int fs_mask);
        cw = '0; nbits = 0; fs_mask = 0;
        in_valid0 = 1'b1; in_data0 = d; inj_en0 = ie; inj_pos0 = ip;
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_data0 = 4'($urandom); inj_en0 = 1'($urandom); inj_pos0 = 3'($urandom);
        lat = 1;
        for (int k = 0; k < 10 && !bv0; k++) begin
            @(posedge clk); #1;
            lat++;
        end
        while (bv0 && nbits < 16) begin
            cw = {cw[5:0], serial0};
            if (fs0) fs_mask |= (1 << nbits);
            nbits++;
            @(posedge clk); #1;
        end
    endtask

    // Offers two nibbles with in_valid held high and logs 32 cycles of outputs.
    task automatic run_pair(input bit sel, input logic [3:0] a, input logic [3:0] b);
        int  sent;
        logic rdy;
        sent = 0;
        lg_bv = '0; lg_ser = '0; lg_fs = '0; lg_rdy = '0; lg_busy = '0;
        if (sel) begin in_valid1 = 1'b1; in_data1 = a; inj_en1 = 1'b0; end
        else     begin in_valid0 = 1'b1; in_data0 = a; inj_en0 = 1'b0; end
        for (int c = 0; c < 32; c++) begin
            rdy = sel ? in_ready1 : in_ready0;
            @(posedge clk); #1;
            if ((sel ? in_valid1 : in_valid0) && rdy) begin
                sent++;
                if (sel) begin
                    if (sent == 2) in_valid1 = 1'b0;
                    in_data1 = b;
                end else begin
                    if (sent == 2) in_valid0 = 1'b0;
                    in_data0 = b;
                end
            end
            lg_bv[c]   = sel ? bv1 : bv0;
            lg_ser[c]  = sel ? serial1 : serial0;
            lg_fs[c]   = sel ? fs1 : fs0;
            lg_rdy[c]  = sel ? in_ready1 : in_ready0;
            lg_busy[c] = sel ? busy1 : busy0;
        end
    endtask

    function automatic logic [13:0] logged_bits();
        logic [13:0] w;
        w = '0;
        for (int c = 0; c < 32; c++) begin
            if (lg_bv[c]) w = {w[12:0], lg_ser[c]};
        end
        return w;
    endfunction

    initial begin
        logic [6:0] cw;
        int lat, nbits, fs_mask, cnt;

        n_checks = 0; n_fail = 0;
        reset = 1'b0;
        in_valid0 = 0; in_data0 = '0; inj_en0 = 0; inj_pos0 = '0;
        in_valid1 = 0; in_data1 = '0; inj_en1 = 0; inj_pos1 = '0;

        vecs[0] = '{4'b1011, 1'b0, 3'd0, 7'b1010101};
        vecs[1] = '{4'b0000, 1'b0, 3'd0, 7'b0000000};
        vecs[2] = '{4'b0001, 1'b0, 3'd0, 7'b0000111};
        vecs[3] = '{4'b1111, 1'b0, 3'd0, 7'b1111111};
        vecs[4] = '{4'b1011, 1'b1, 3'd6, 7'b0010101};
        vecs[5] = '{4'b1011, 1'b1, 3'd7, 7'b1010101};
        vecs[6] = '{4'b0000, 1'b1, 3'd0, 7'b0000001};

        repeat (2) @(posedge clk);
        #1;
        check("reset_serial", 32'(serial0), 32'd0);
        check("reset_bit_valid", 32'(bv0), 32'd0);
        check("reset_frame_start", 32'(fs0), 32'd0);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_in_ready", 32'(in_ready0), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_frame(vecs[i].data, vecs[i].inj_en, vecs[i].inj_pos, cw, lat, nbits, fs_mask);
            check($sformatf("vec%0d_cw", i), 32'(cw), 32'(vecs[i].exp_cw));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_nbits", i), 32'(nbits), 32'd7);
            check($sformatf("vec%0d_fs_mask", i), 32'(fs_mask), 32'd1);
        end

        for (int n = 0; n < 16; n++) begin
            run_frame(4'(n), 1'b0, 3'd7, cw, lat, nbits, fs_mask);
            check($sformatf("sweep_%0h_cw", n), 32'(cw), 32'(ref_encode(4'(n))));
        end

        run_pair(1'b0, 4'b1011, 4'b0001);
        check("b2b_bit_valid", lg_bv, 32'h0000_7FFE);
        check("b2b_frame_start", lg_fs, 32'h0000_0102);
        check("b2b_in_ready", 32'(lg_rdy[8:0]), 32'b1_0000_0010);
        check("b2b_busy", lg_busy, 32'h0000_7FFF);
        check("b2b_bits", 32'(logged_bits()), 32'({7'b1010101, 7'b0000111}));

        run_pair(1'b1, 4'b1111, 4'b1011);
        check("gap_bit_valid", lg_bv, 32'h0003_F8FE);
        check("gap_frame_start", lg_fs, 32'h0000_0802);
        check("gap_busy", lg_busy, 32'h001F_FFFF);
        check("gap_bits", 32'(logged_bits()), 32'({7'b1111111, 7'b1010101}));

        in_valid0 = 1'b1; in_data0 = 4'hF; inj_en0 = 1'b0;
        @(posedge clk); #1;
        in_data0 = 4'hB;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_bit_valid", 32'(bv0), 32'd1);
        check("rst_pre_serial", 32'(serial0), 32'd1);
        check("rst_pre_hold_full", 32'(in_ready0), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_async_serial", 32'(serial0), 32'd0);
        check("rst_async_bit_valid", 32'(bv0), 32'd0);
        check("rst_async_in_ready", 32'(in_ready0), 32'd1);
        check("rst_async_busy", 32'(busy0), 32'd0);
        @(posedge clk); #2 reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bv0 || busy0) cnt++;
        end
        check("rst_no_stale_frame", 32'(cnt), 32'd0);
        run_frame(4'b0001, 1'b0, 3'd0, cw, lat, nbits, fs_mask);
        check("rst_after_cw", 32'(cw), 32'b0000111);
        check("rst_after_nbits", 32'(nbits), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
